// File: rtl/kpyd_debouncer_if.sv
// kpyd_debouncer_if: raw key contact in, filtered level and glitch flag out.
interface kpyd_debouncer_if;
  logic raw_i;
  logic debounce_o;
  logic bounce_o;
  modport master (output raw_i, input debounce_o, bounce_o);
  modport slave (input raw_i, output debounce_o, bounce_o);
endinterface

// File: rtl/kpyd_debouncer.sv
// kpyd_debouncer: keypad contact stability filter; define KPYD_DEBOUNCE_SYNC_EN to add a two-flop input synchronizer.
module kpyd_debouncer #(
  parameter int CYCLES_P = 16
) (
  input logic clk_i,
  input logic reset_i,
  kpyd_debouncer_if.slave kp
);
  localparam int CW = $clog2(CYCLES_P + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES_P - 1);
  typedef enum logic [1:0] {
    released_s     = 2'b00,
    press_wait_s   = 2'b01,
    pressed_s      = 2'b10,
    release_wait_s = 2'b11
  } state_t;
  state_t state_r, state_n;
  logic [CW-1:0] cnt_r, cnt_n;
  logic bounce_r, bounce_n;
  logic s;
`ifdef KPYD_DEBOUNCE_SYNC_EN
  logic [1:0] sync_r;
  always_ff @(posedge clk_i)
    sync_r <= reset_i ? 2'b00 : {sync_r[0], kp.raw_i};
  assign s = sync_r[1];
`else
  assign s = kp.raw_i;
`endif
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    bounce_n = 1'b0;
    case (state_r)
      released_s: begin
        state_n = s ? press_wait_s : released_s;
        cnt_n   = s ? CW'(1) : '0;
      end
      press_wait_s: begin
        state_n  = !s ? released_s : (cnt_r == LAST) ? pressed_s : press_wait_s;
        cnt_n    = (!s || cnt_r == LAST) ? '0 : cnt_r + CW'(1);
        bounce_n = !s;
      end
      pressed_s: begin
        state_n = !s ? release_wait_s : pressed_s;
        cnt_n   = !s ? CW'(1) : '0;
      end
      release_wait_s: begin
        state_n  = s ? pressed_s : (cnt_r == LAST) ? released_s : release_wait_s;
        cnt_n    = (s || cnt_r == LAST) ? '0 : cnt_r + CW'(1);
        bounce_n = s;
      end
      default: begin
        state_n = released_s;
        cnt_n   = '0;
      end
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= released_s;
      cnt_r    <= '0;
      bounce_r <= 1'b0;
    end else begin
      state_r  <= state_n;
      cnt_r    <= cnt_n;
      bounce_r <= bounce_n;
    end
  end
  // Level is the upper state bit: high in pressed_s and release_wait_s only.
  assign kp.debounce_o = state_r[1];
  assign kp.bounce_o   = bounce_r;
endmodule
